xdatabus_rd_ctrl: RTL and testbench

//  Burst read master directly upstream of the databus address decoder. Accepts a command
//  (start address, word count), issues one req/addr per cycle to the decoder, captures the

---
 rtl/xdatabus_rd_ctrl_pkg.sv | 16 +
 rtl/xdatabus_rd_ctrl_fifo.sv | 52 +++++
 rtl/xdatabus_rd_ctrl.sv | 136 +++++++++++++
 tb/tb_xdatabus_rd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdatabus_rd_ctrl_pkg.sv
// Shared definitions for the databus burst read controller: default widths and FSM encoding.
// Optional feature macro used by the top: XDATABUS_RD_STRIDE_EN.
package xdatabus_rd_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned LEN_W_DEF      = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } rd_state_e;

endpackage

// File: rtl/xdatabus_rd_ctrl_fifo.sv
// Show-ahead synchronous FIFO holding returned words plus their last flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module xdatabus_rd_ctrl_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign do_push  = push && (cnt_q != FULL_CNT);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr_q];
  assign count    = cnt_q;

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr_q] <= push_data;
        wptr_q      <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/xdatabus_rd_ctrl.sv
// Burst read master in front of the databus address decoder. Issues one request per cycle,
// captures the word returned a cycle later into a small FIFO, and limits issue by credits
// so a stalled consumer never causes a returned word to be dropped.
// Optional: XDATABUS_RD_STRIDE_EN adds cmd_stride (latched on accept) as the address step.
module xdatabus_rd_ctrl
  import xdatabus_rd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
`ifdef XDATABUS_RD_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride,
`endif
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, step;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              inflight_q, inflight_last_q;
  logic              done_q, done_d;
  logic              accept, pop, head_last, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;

  assign accept      = cmd_valid && cmd_ready;
  // Words buffered plus the word still on its way back must leave room for one more.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign rd_valid    = !fifo_empty;
  assign rd_last     = head_last;
  assign pop         = rd_valid && rd_ready;
  assign bus_addr    = addr_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;

`ifdef XDATABUS_RD_STRIDE_EN
  logic [ADDR_W-1:0] step_q;
  // Stride is captured with the command so the burst is immune to later port changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         step_q <= '0;
    else if (accept) step_q <= cmd_stride;
  end
  assign step = step_q;
`else
  assign step = ADDR_W'(1);
`endif

  // Next-state, request issue and address/remaining-count update.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    done_d    = 1'b0;
    bus_req   = 1'b0;
    cmd_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = StIssue;
        end
      end
      StIssue: begin
        if (credit_used < DEPTH_V) begin
          bus_req  = 1'b1;
          addr_d   = addr_q + step;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; done is registered so it pulses the cycle after the final pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= bus_req;
      inflight_last_q <= bus_req && (remain_q == LEN_W'(1));
      done_q          <= done_d;
    end
  end

  xdatabus_rd_ctrl_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, bus_data_in}),
    .pop       (pop),
    .pop_data  ({head_last, rd_data}),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_xdatabus_rd_ctrl.sv
// Directed bench for xdatabus_rd_ctrl with a one-cycle-latency decoder model.
module tb_xdatabus_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
`ifdef XDATABUS_RD_STRIDE_EN
  logic [15:0] cmd_stride = '0;
`endif
  logic        bus_req;
  logic [15:0] bus_addr;
  logic [31:0] bus_data_in = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] req_addr[$];
  int          req_cyc[$];
  logic [31:0] pop_data[$];
  logic        pop_last[$];
  int          pop_cyc[$];
  int          done_cyc[$];
  logic        hold_req, hold_valid;

  xdatabus_rd_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
`ifdef XDATABUS_RD_STRIDE_EN
    .cmd_stride  (cmd_stride),
`endif
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_data_in (bus_data_in),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Decoder model: word for the requested address appears the cycle after bus_req.
  always @(posedge clk) bus_data_in <= bus_req ? data_of(bus_addr) : 32'hDEAD_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [15:0] a, input logic [15:0] len, input logic [15:0] st);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
`ifdef XDATABUS_RD_STRIDE_EN
    cmd_stride = st;
`else
    if (st != 16'd1) $display("note: stride ignored in this build");
`endif
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cmd_ready_before_accept: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Records requests, pops and done pulses; cycle 1 is the first cycle after accept.
  task automatic collect(input int max_cyc, input int hold0, input bit rand_ready);
    req_addr.delete(); req_cyc.delete();
    pop_data.delete(); pop_last.delete(); pop_cyc.delete(); done_cyc.delete();
    hold_req = 1'b0; hold_valid = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (k <= hold0)     rd_ready = 1'b0;
      else if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
      else                rd_ready = 1'b1;
      if (k == hold0) begin
        hold_req   = bus_req;
        hold_valid = rd_valid;
      end
      if (bus_req) begin
        req_addr.push_back(bus_addr);
        req_cyc.push_back(k);
      end
      if (rd_valid && rd_ready) begin
        pop_data.push_back(rd_data);
        pop_last.push_back(rd_last);
        pop_cyc.push_back(k);
      end
      if (done) done_cyc.push_back(k);
      if (done_cyc.size() != 0 && k >= done_cyc[0] + 2) break;
      tick();
    end
    rd_ready = 1'b0;
  endtask

  // Checks the recorded burst against a linear address sequence.
  task automatic check_burst(input string tag, input logic [15:0] base, input logic [15:0] st,
                             input int len);
    logic [15:0] a;
    n_cmp++;
    if (req_addr.size() != len) begin
      n_bad++;
      $display("FAIL %s_req_count: got %0d want %0d", tag, req_addr.size(), len);
    end
    n_cmp++;
    if (pop_data.size() != len) begin
      n_bad++;
      $display("FAIL %s_pop_count: got %0d want %0d", tag, pop_data.size(), len);
    end
    a = base;
    for (int i = 0; i < len; i++) begin
      if (i < req_addr.size()) begin
        n_cmp++;
        if (req_addr[i] !== a) begin
          n_bad++;
          $display("FAIL %s_bus_addr[%0d]: got %h want %h", tag, i, req_addr[i], a);
        end
      end
      if (i < pop_data.size()) begin
        n_cmp++;
        if ({pop_last[i], pop_data[i]} !== {(i == len - 1), data_of(a)}) begin
          n_bad++;
          $display("FAIL %s_word[%0d]: got %b/%h want %b/%h", tag, i, pop_last[i], pop_data[i],
                   (i == len - 1), data_of(a));
        end
      end
      a = a + st;
    end
    n_cmp++;
    if (done_cyc.size() != 1 || pop_cyc.size() == 0 || done_cyc[0] != pop_cyc[$] + 1) begin
      n_bad++;
      $display("FAIL %s_done_pulse: got %0d pulses, want one the cycle after last pop", tag,
               done_cyc.size());
    end
    n_cmp++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL %s_idle_after: got busy/ready %b%b want 01", tag, busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({cmd_ready, bus_req, rd_valid, rd_last, busy, done, bus_addr, rd_data}
        !== {1'b1, 5'b0, 16'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy%b req%b val%b last%b busy%b done%b a%h d%h",
               cmd_ready, bus_req, rd_valid, rd_last, busy, done, bus_addr, rd_data);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_burst();
    issue_cmd(16'h0100, 16'd4, 16'd1);
    collect(30, 0, 1'b0);
    check_burst("basic", 16'h0100, 16'd1, 4);
    n_cmp++;
    if (req_cyc.size() != 4 || req_cyc[0] != 1 || req_cyc[3] != 4) begin
      n_bad++;
      $display("FAIL basic_req_timing: got %0d reqs not on cycles 1..4", req_cyc.size());
    end
    // Request on cycle 1, data back cycle 2, visible at the FIFO head cycle 3.
    n_cmp++;
    if (pop_cyc.size() == 0 || pop_cyc[0] != 3) begin
      n_bad++;
      $display("FAIL basic_first_valid: got cycle %0d want 3",
               pop_cyc.size() ? pop_cyc[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    tick();
    issue_cmd(16'h0200, 16'd8, 16'd1);
    collect(60, 10, 1'b0);
    n_cmp++;
    if (req_cyc.size() < 5 || req_cyc[3] != 4 || req_cyc[4] <= 10) begin
      n_bad++;
      $display("FAIL bp_credit_stall: got %0d reqs, fifth not held past hold window",
               req_cyc.size());
    end
    n_cmp++;
    if ({hold_req, hold_valid} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_hold_state: got req/valid %b%b want 01", hold_req, hold_valid);
    end
    check_burst("bp", 16'h0200, 16'd1, 8);
  endtask

  task automatic test_zero_len();
    tick();
    issue_cmd(16'h0300, 16'd0, 16'd1);
    n_cmp++;
    if ({done, cmd_ready, busy} !== 3'b110) begin
      n_bad++;
      $display("FAIL zero_len_next: got done/ready/busy %b%b%b want 110", done, cmd_ready, busy);
    end
    collect(6, 0, 1'b0);
    n_cmp++;
    if (req_addr.size() != 0 || pop_data.size() != 0 || done_cyc.size() != 1) begin
      n_bad++;
      $display("FAIL zero_len_traffic: got %0d reqs %0d pops %0d dones want 0/0/1",
               req_addr.size(), pop_data.size(), done_cyc.size());
    end
  endtask

  task automatic test_wrap();
    tick();
    issue_cmd(16'hFFFE, 16'd3, 16'd1);
    collect(30, 0, 1'b0);
    check_burst("wrap", 16'hFFFE, 16'd1, 3);
  endtask

  task automatic test_reset_mid_burst();
    tick();
    issue_cmd(16'h0040, 16'd6, 16'd1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({cmd_ready, bus_req, rd_valid, rd_last, busy, done, bus_addr, rd_data}
        !== {1'b1, 5'b0, 16'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL midrst_outputs: got rdy%b req%b val%b last%b busy%b done%b a%h d%h",
               cmd_ready, bus_req, rd_valid, rd_last, busy, done, bus_addr, rd_data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_discard: got rd_valid %b want 0", rd_valid);
    end
    issue_cmd(16'h0020, 16'd1, 16'd1);
    collect(20, 0, 1'b0);
    check_burst("midrst", 16'h0020, 16'd1, 1);
  endtask

`ifdef XDATABUS_RD_STRIDE_EN
  task automatic test_stride();
    tick();
    issue_cmd(16'h0010, 16'd3, 16'd4);
    collect(80, 0, 1'b1);
    check_burst("stride", 16'h0010, 16'd4, 3);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid_burst();
`ifdef XDATABUS_RD_STRIDE_EN
    test_stride();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
